rgb_assemble: RTL and testbench

//  Receiver-side reassembly for the per-channel RGB stream: accepts (value, index) beats,
//  one colour channel per beat, and rebuilds full R/G/B pixel triples.

---
 rtl/rgb_pkg.sv | 14 +
 rtl/rgb_assemble_if.sv | 27 ++
 rtl/sat_counter.sv | 26 ++
 rtl/rgb_assemble.sv | 129 ++++++++++++
 tb/tb_rgb_assemble.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB channel reassembly block.
package rgb_pkg;

    localparam int W_DEFAULT = 10;

    localparam logic [1:0] CH_R    = 2'd0;
    localparam logic [1:0] CH_G    = 2'd1;
    localparam logic [1:0] CH_B    = 2'd2;
    localparam logic [1:0] CH_SYNC = 2'd3;

    // One bit per colour channel currently held: bit0=R, bit1=G, bit2=B.
    typedef logic [2:0] chan_mask_t;

endpackage

// File: rtl/rgb_assemble_if.sv
// Beat input and pixel output bundle of rgb_assemble.
// slave: the reassembler; master: the beat source / pixel consumer.
interface rgb_assemble_if #(
    parameter int W = rgb_pkg::W_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] value;
    logic [1:0]   index;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] red;
    logic [W-1:0] green;
    logic [W-1:0] blue;
    logic         sol;
    logic         err;

    modport slave (
        input  in_valid, value, index, out_ready,
        output in_ready, out_valid, red, green, blue, sol, err
    );

    modport master (
        output in_valid, value, index, out_ready,
        input  in_ready, out_valid, red, green, blue, sol, err
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/rgb_assemble.sv
// Rebuilds R/G/B pixel triples from one-channel-per-beat (value, index) beats.
// Index 3 is a SYNC marker that drops any partial pixel.
// Optional macro RGB_ORDER_CHECK_EN: enforce strict R, G, B arrival order.
module rgb_assemble
    import rgb_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    rgb_assemble_if.slave    bus,
    output logic [CNT_W-1:0] err_cnt
);
    chan_mask_t          mask_q, mask_d, mask_n, bit_sel;
    logic [2:0][W-1:0]   hold_q, hold_d;
    logic [W-1:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                out_valid_q, out_valid_d;
    logic                sol_q, sol_d, err_q, err_d;
    logic                accept, xfer;
`ifdef RGB_ORDER_CHECK_EN
    chan_mask_t          exp_sel;
    // Next channel due in strict order; the mask is always an R/RG prefix.
    assign exp_sel = (mask_q == 3'b000) ? 3'b001 :
                     (mask_q == 3'b001) ? 3'b010 : 3'b100;
`endif

    // A new beat fits whenever the output register is empty or draining now.
    assign bus.in_ready = ce & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign xfer         = out_valid_q & ce & bus.out_ready;
    // SYNC shifts the one out of the 3-bit field, giving an empty select.
    assign bit_sel      = chan_mask_t'(3'b001 << bus.index);

    // Beat decode, channel capture, pixel completion and error/sync pulses.
    always_comb begin
        mask_d      = mask_q;
        mask_n      = mask_q;
        hold_d      = hold_q;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        out_valid_d = out_valid_q & ~xfer;
        sol_d       = 1'b0;
        err_d       = 1'b0;
        if (accept) begin
            if (bus.index == CH_SYNC) begin
                sol_d  = 1'b1;
                err_d  = |mask_q;
                mask_n = '0;
            end else begin
`ifdef RGB_ORDER_CHECK_EN
                if (bit_sel != exp_sel) begin
                    // Out-of-order beat: drop the pixel; only an R may restart it.
                    err_d  = 1'b1;
                    mask_n = '0;
                    if (bus.index == CH_R) begin
                        hold_d[0] = bus.value;
                        mask_n    = 3'b001;
                    end
                end else begin
                    for (int c = 0; c < 3; c++)
                        if (bit_sel[c]) hold_d[c] = bus.value;
                    mask_n = mask_q | bit_sel;
                end
`else
                // A repeated channel abandons the old pixel and starts a new one.
                if (|(mask_q & bit_sel)) begin
                    err_d  = 1'b1;
                    mask_n = bit_sel;
                end else begin
                    mask_n = mask_q | bit_sel;
                end
                for (int c = 0; c < 3; c++)
                    if (bit_sel[c]) hold_d[c] = bus.value;
`endif
            end
            if (mask_n == 3'b111) begin
                red_d       = hold_d[0];
                green_d     = hold_d[1];
                blue_d      = hold_d[2];
                out_valid_d = 1'b1;
                mask_n      = '0;
            end
            mask_d = mask_n;
        end
    end

    // State registers; ce freezes everything, pulses drop to 0 while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q      <= '0;
            hold_q      <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            out_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sol_q <= sol_d;
            err_q <= err_d;
            if (ce) begin
                mask_q      <= mask_d;
                hold_q      <= hold_d;
                red_q       <= red_d;
                green_q     <= green_d;
                blue_q      <= blue_d;
                out_valid_q <= out_valid_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q & ce;
    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
    assign bus.sol       = sol_q;
    assign bus.err       = err_q;

    // err_d is already zero while ce is low, so the count freezes with the rest.
    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_d),
        .count (err_cnt)
    );
endmodule

// File: tb/tb_rgb_assemble.sv
// Self-checking bench for rgb_assemble: directed scenarios then random traffic,
// every cycle compared against a channel-slot / pixel-queue reference model.
module tb_rgb_assemble;
    import rgb_pkg::*;

    localparam int W     = 10;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;
`ifdef RGB_ORDER_CHECK_EN
    localparam int E2 = 1;
`else
    localparam int E2 = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ce = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    rgb_assemble_if #(.W(W)) bus();

    rgb_assemble #(.W(W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-channel slots, pending pixels, expected pulses.
    logic [W-1:0]     m_val[3];
    bit               m_have[3];
    logic [3*W-1:0]   px_q[$];
    logic [3*W-1:0]   got[$];
    bit               m_sol, m_err, last_acc;
    int               m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        for (int c = 0; c < 3; c++) m_have[c] = 1'b0;
    endfunction

    function automatic void m_bump_err();
        m_err = 1'b1;
        if (m_cnt < SAT) m_cnt++;
    endfunction

    function automatic void m_beat(input logic [1:0] idx, input logic [W-1:0] v);
        int nxt;
        if (idx == 2'd3) begin
            m_sol = 1'b1;
            if (m_have[0] || m_have[1] || m_have[2]) m_bump_err();
            m_clear();
            return;
        end
`ifdef RGB_ORDER_CHECK_EN
        nxt = !m_have[0] ? 0 : (!m_have[1] ? 1 : 2);
        if (int'(idx) != nxt) begin
            m_bump_err();
            m_clear();
            if (idx == 2'd0) begin
                m_have[0] = 1'b1;
                m_val[0]  = v;
            end
            return;
        end
`else
        nxt = 0;
        if (m_have[idx]) begin
            m_bump_err();
            m_clear();
        end
`endif
        m_have[idx] = 1'b1;
        m_val[idx]  = v;
        if (m_have[0] && m_have[1] && m_have[2]) begin
            px_q.push_back({m_val[0], m_val[1], m_val[2]});
            m_clear();
        end
    endfunction

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        logic exp_rdy;
        bit   xfer;
        @(negedge clk);
        exp_rdy = ce & ((px_q.size() == 0) | bus.out_ready);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, ce & (px_q.size() != 0));
        if (px_q.size() != 0) chk("pixel", {bus.red, bus.green, bus.blue}, px_q[0]);
        chk("sol", bus.sol, m_sol);
        chk("err", bus.err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        last_acc = bus.in_valid & exp_rdy;
        xfer     = ce & bus.out_ready & (px_q.size() != 0);
        m_sol    = 1'b0;
        m_err    = 1'b0;
        if (xfer) begin
            got.push_back({bus.red, bus.green, bus.blue});
            void'(px_q.pop_front());
        end
        if (!rst_n) begin
            m_clear();
            px_q.delete();
            m_cnt = 0;
        end else if (last_acc) begin
            m_beat(bus.index, bus.value);
        end
        @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted (bounded); returns just after the accepting edge.
    task automatic send(input logic [1:0] idx, input logic [W-1:0] v);
        bus.in_valid = 1'b1;
        bus.index    = idx;
        bus.value    = v;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (last_acc) break;
        end
        chk("beat_accepted", last_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.index     = 2'd0;
        bus.value     = '0;
        bus.out_ready = 1'b1;
        ce            = 1'b1;
        rst_n         = 1'b0;
        m_clear();
        m_cnt = 0; m_sol = 0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
        chk("rst_sol_err", {bus.sol, bus.err}, 2'b00);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        cycle();

        // 1: in-order pixel
        send(CH_R, 10'h100); send(CH_G, 10'h200); send(CH_B, 10'h3FF);
        cycle(); cycle();
        chk("t1_count", got.size(), 1);
        chk("t1_pixel", got[0], {10'h100, 10'h200, 10'h3FF});
        chk("t1_err_cnt", err_cnt, 0);

        // 2: out-of-order B, R, G
        send(CH_B, 10'd5); send(CH_R, 10'd6); send(CH_G, 10'd7);
`ifdef RGB_ORDER_CHECK_EN
        cycle();
        chk("t2_no_pixel", got.size(), 1);
        send(CH_B, 10'd8);
        cycle(); cycle();
        chk("t2_pixel", got[1], {10'd6, 10'd7, 10'd8});
`else
        cycle(); cycle();
        chk("t2_pixel", got[1], {10'd6, 10'd7, 10'd5});
`endif
        chk("t2_err_cnt", err_cnt, E2);

        // 3: duplicate R restarts the pixel
        send(CH_R, 10'd1);
        send(CH_R, 10'd2);
        chk("t3_err_pulse", bus.err, 1'b1);
        send(CH_G, 10'd3); send(CH_B, 10'd4);
        cycle(); cycle();
        chk("t3_pixel", got[2], {10'd2, 10'd3, 10'd4});
        chk("t3_err_cnt", err_cnt, E2 + 1);

        // 4: SYNC on a partial pixel, then a clean SYNC
        send(CH_R, 10'd9); send(CH_G, 10'd10);
        send(CH_SYNC, 10'd0);
        chk("t4_sol", bus.sol, 1'b1);
        chk("t4_err", bus.err, 1'b1);
        send(CH_SYNC, 10'd0);
        chk("t4_sol2", bus.sol, 1'b1);
        chk("t4_err2", bus.err, 1'b0);
        cycle();
        chk("t4_no_pixel", got.size(), 3);
        chk("t4_err_cnt", err_cnt, E2 + 2);

        // 5: back-pressure holds the pending pixel and blocks input
        base = got.size();
        bus.out_ready = 1'b0;
        send(CH_R, 10'h11); send(CH_G, 10'h22); send(CH_B, 10'h33);
        bus.in_valid = 1'b1; bus.index = CH_R; bus.value = 10'h44;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t5_blocked", last_acc, 1'b0);
            chk("t5_stable", {bus.red, bus.green, bus.blue}, {10'h11, 10'h22, 10'h33});
        end
        bus.out_ready = 1'b1;
        send(CH_R, 10'h44); send(CH_G, 10'h55); send(CH_B, 10'h66);
        cycle(); cycle();
        chk("t5_count", got.size() - base, 2);
        chk("t5_first", got[base], {10'h11, 10'h22, 10'h33});
        chk("t5_second", got[base + 1], {10'h44, 10'h55, 10'h66});

        // 6: counter saturation, then reset mid-pixel / with output pending
        for (int k = 0; k < 301; k++) send(CH_R, W'(k));
        cycle();
        chk("t6_saturated", err_cnt, SAT);
        send(CH_G, 10'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_rst_rgb", {bus.red, bus.green, bus.blue}, 0);
        chk("t6_rst_cnt", err_cnt, 0);
        chk("t6_rst_err", bus.err, 1'b0);
        send(CH_SYNC, 10'd0);
        chk("t6_sync_clean", {bus.sol, bus.err}, 2'b10);
        bus.out_ready = 1'b0;
        send(CH_R, 10'd1); send(CH_G, 10'd2); send(CH_B, 10'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_rst_out_valid", bus.out_valid, 1'b0);
        chk("t6_rst_rgb2", {bus.red, bus.green, bus.blue}, 0);
        bus.out_ready = 1'b1;

        // 7: ce low freezes everything
        send(CH_R, 10'd7);
        ce = 1'b0;
        bus.in_valid = 1'b1; bus.index = CH_R; bus.value = 10'd8;
        repeat (3) cycle();
        ce = 1'b1;
        bus.in_valid = 1'b0;
        send(CH_G, 10'd9); send(CH_B, 10'd10);
        cycle(); cycle();
        chk("t7_pixel", got[got.size() - 1], {10'd7, 10'd9, 10'd10});

        // 8: random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.index     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.value     = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ce            = ($urandom_range(0, 7) != 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1; ce = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
